// File: rtl/seq_alu_core.sv
// seq_alu_core: handshaked sequential ALU.
// Single-cycle logic/arith/compare ops, iterative one-bit-per-cycle shifts and,
// when SEQ_ALU_MUL_EN is defined, a WIDTH-iteration shift-add multiplier.
// Results and flags are registered and change only on entry to DONE.
module seq_alu_core #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_code,
   input  logic [WIDTH-1:0] reg_data1,
   input  logic [WIDTH-1:0] reg_data2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] accum,
   output logic             pc_branch,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v,
   output logic             flag_err
);

   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = SHW + 1;

   localparam logic [3:0] OP_ADD = 4'b1000;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b1010;
   localparam logic [3:0] OP_SLL = 4'b0001;
   localparam logic [3:0] OP_SRL = 4'b0101;
   localparam logic [3:0] OP_BEQ = 4'b1100;
   localparam logic [3:0] OP_BLT = 4'b1101;
   localparam logic [3:0] OP_BGT = 4'b1110;
`ifdef SEQ_ALU_MUL_EN
   localparam logic [3:0] OP_MUL = 4'b1001;
`endif

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   // Two's-complement overflow of a+b: operands agree in sign, result does not.
   function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                    input logic signed [WIDTH-1:0] b,
                                    input logic signed [WIDTH-1:0] r);
      return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
   endfunction

   // Two's-complement overflow of a-b: operands differ in sign, result sign flips from a.
   function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                    input logic signed [WIDTH-1:0] b,
                                    input logic signed [WIDTH-1:0] r);
      return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
   endfunction

   state_t           state_q, state_d;
   logic [3:0]       code_q, code_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] accum_q, accum_d;
   logic             pc_q, pc_d, z_q, z_d, c_q, c_d, v_q, v_d, err_q, err_d;

   logic [WIDTH:0]   sum_w, diff_w;
   logic [WIDTH-1:0] sc_res, shift_step;
   logic             sc_pc, sc_c, sc_v, sc_err, is_shift;

`ifdef SEQ_ALU_MUL_EN
   logic [2*WIDTH-1:0] prod_q, prod_d, prod_step;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH:0]     mul_sum;

   // One shift-add step: add multiplicand to the high half when the low bit is set, then shift right.
   assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
   assign prod_step = {mul_sum, prod_q[WIDTH-1:1]};
`endif

   assign sum_w      = {1'b0, reg_data1} + {1'b0, reg_data2};
   assign diff_w     = {1'b0, reg_data1} - {1'b0, reg_data2};
   assign is_shift   = (alu_code == OP_SLL) || (alu_code == OP_SRL);
   assign shift_step = (code_q == OP_SLL) ? (work_q << 1) : (work_q >> 1);
   assign in_ready   = (state_q == IDLE) && rst_n;

   // Single-cycle result and flags, evaluated straight from the presented operands.
   always_comb begin
      sc_res = '0;
      sc_pc  = 1'b0;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      sc_err = 1'b0;
      case (alu_code)
         OP_ADD: begin
            sc_res = sum_w[WIDTH-1:0];
            sc_c   = sum_w[WIDTH];
            sc_v   = add_ovf(reg_data1, reg_data2, sum_w[WIDTH-1:0]);
         end
         OP_SUB, OP_BEQ, OP_BLT, OP_BGT: begin
            sc_res = diff_w[WIDTH-1:0];
            sc_c   = diff_w[WIDTH];
            sc_v   = sub_ovf(reg_data1, reg_data2, diff_w[WIDTH-1:0]);
         end
         OP_AND:         sc_res = reg_data1 & reg_data2;
         OP_OR:          sc_res = reg_data1 | reg_data2;
         OP_XOR:         sc_res = reg_data1 ^ reg_data2;
         OP_SLL, OP_SRL: sc_err = 1'b0;
`ifdef SEQ_ALU_MUL_EN
         OP_MUL:         sc_err = 1'b0;
`endif
         default:        sc_err = 1'b1;
      endcase
      case (alu_code)
         OP_BEQ:  sc_pc = (reg_data1 == reg_data2);
         OP_BLT:  sc_pc = (reg_data1 <  reg_data2);
         OP_BGT:  sc_pc = (reg_data1 >  reg_data2);
         default: sc_pc = 1'b0;
      endcase
   end

   // Next-state logic: accept in IDLE, iterate in BUSY, hold the result in DONE.
   always_comb begin
      state_d     = state_q;
      code_d      = code_q;
      work_d      = work_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      accum_d     = accum_q;
      pc_d        = pc_q;
      z_d         = z_q;
      c_d         = c_q;
      v_d         = v_q;
      err_d       = err_q;
`ifdef SEQ_ALU_MUL_EN
      prod_d      = prod_q;
      mcand_d     = mcand_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               code_d = alu_code;
               work_d = reg_data1;
               if (is_shift && (reg_data2[SHW-1:0] != '0)) begin
                  state_d = BUSY;
                  cnt_d   = {1'b0, reg_data2[SHW-1:0]};
`ifdef SEQ_ALU_MUL_EN
               end else if (alu_code == OP_MUL) begin
                  state_d = BUSY;
                  cnt_d   = CW'(WIDTH);
                  prod_d  = {{WIDTH{1'b0}}, reg_data1};
                  mcand_d = reg_data2;
`endif
               end else if (is_shift) begin
                  // Zero shift amount: the operand passes through unchanged.
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  accum_d     = reg_data1;
                  z_d         = (reg_data1 == '0);
                  pc_d        = 1'b0;
                  c_d         = 1'b0;
                  v_d         = 1'b0;
                  err_d       = 1'b0;
               end else begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  accum_d     = sc_res;
                  z_d         = !sc_err && (sc_res == '0);
                  pc_d        = sc_pc;
                  c_d         = sc_c;
                  v_d         = sc_v;
                  err_d       = sc_err;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CW'(1);
`ifdef SEQ_ALU_MUL_EN
            if (code_q == OP_MUL) begin
               prod_d = prod_step;
               if (cnt_q == CW'(1)) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  accum_d     = prod_step[WIDTH-1:0];
                  z_d         = (prod_step[WIDTH-1:0] == '0);
                  v_d         = |prod_step[2*WIDTH-1:WIDTH];
                  pc_d        = 1'b0;
                  c_d         = 1'b0;
                  err_d       = 1'b0;
               end
            end else
`endif
            begin
               work_d = shift_step;
               if (cnt_q == CW'(1)) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  accum_d     = shift_step;
                  z_d         = (shift_step == '0);
                  v_d         = 1'b0;
                  pc_d        = 1'b0;
                  c_d         = 1'b0;
                  err_d       = 1'b0;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and visible result registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         accum_q     <= '0;
         pc_q        <= 1'b0;
         z_q         <= 1'b0;
         c_q         <= 1'b0;
         v_q         <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         accum_q     <= accum_d;
         pc_q        <= pc_d;
         z_q         <= z_d;
         c_q         <= c_d;
         v_q         <= v_d;
         err_q       <= err_d;
      end
   end

   // Datapath working registers; only meaningful while BUSY, so left unreset.
   always_ff @(posedge clk) begin
      code_q  <= code_d;
      work_q  <= work_d;
`ifdef SEQ_ALU_MUL_EN
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
`endif
   end

   assign out_valid = out_valid_q;
   assign accum     = accum_q;
   assign pc_branch = pc_q;
   assign flag_z    = z_q;
   assign flag_c    = c_q;
   assign flag_v    = v_q;
   assign flag_err  = err_q;

endmodule

// File: tb/tb_seq_alu_core.sv
// Bench for seq_alu_core: scoreboard of expected results, one task per scenario.
module tb_seq_alu_core;
   localparam int W = 16;

   localparam logic [3:0] OP_ADD = 4'b1000;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b1010;
   localparam logic [3:0] OP_SLL = 4'b0001;
   localparam logic [3:0] OP_SRL = 4'b0101;
   localparam logic [3:0] OP_MUL = 4'b1001;
   localparam logic [3:0] OP_BEQ = 4'b1100;
   localparam logic [3:0] OP_BLT = 4'b1101;
   localparam logic [3:0] OP_BGT = 4'b1110;

   logic         clk = 1'b0;
   logic         rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [3:0]   alu_code;
   logic [W-1:0] reg_data1, reg_data2, accum;
   logic         pc_branch, flag_z, flag_c, flag_v, flag_err;

   always #5 clk = ~clk;

   seq_alu_core #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_code(alu_code), .reg_data1(reg_data1), .reg_data2(reg_data2),
      .out_valid(out_valid), .out_ready(out_ready), .accum(accum),
      .pc_branch(pc_branch), .flag_z(flag_z), .flag_c(flag_c),
      .flag_v(flag_v), .flag_err(flag_err)
   );

   // Flag field order: pc, z, c, v, err.
   typedef struct packed {
      logic [W-1:0] acc;
      logic pc, z, c, v, err;
      logic [7:0] lat;
   } res_t;

   typedef struct packed {
      logic [3:0]   code;
      logic [W-1:0] a, b;
      res_t         e;
   } vec_t;

   res_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic string fmt(input res_t r);
      return $sformatf("acc=%h pc=%b z=%b c=%b v=%b err=%b lat=%0d",
                       r.acc, r.pc, r.z, r.c, r.v, r.err, r.lat);
   endfunction

   // Reference for the single-cycle arithmetic/logic ops, using integer arithmetic.
   function automatic res_t model(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
      res_t r;
      int   ua, ub, sa, sb, t;
      r = '0;
      r.lat = 8'd1;
      ua = int'(a);
      ub = int'(b);
      sa = (ua >= 32768) ? ua - 65536 : ua;
      sb = (ub >= 32768) ? ub - 65536 : ub;
      case (code)
         OP_ADD: begin
            t = ua + ub;
            r.acc = W'(t);
            r.c = (t > 65535);
            r.v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
         end
         OP_SUB: begin
            t = ua - ub;
            r.acc = W'(t);
            r.c = (ua < ub);
            r.v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
         end
         OP_AND:  r.acc = a & b;
         OP_OR:   r.acc = a | b;
         OP_XOR:  r.acc = a ^ b;
         default: r.err = 1'b1;
      endcase
      r.z = (r.acc == '0) && !r.err;
      return r;
   endfunction

   // Present one op, wait (bounded) for the result, capture it, then consume it.
   task automatic do_op(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                        output res_t obs);
      int lat;
      @(negedge clk);
      alu_code  = code;
      reg_data1 = a;
      reg_data2 = b;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      alu_code  = 4'($urandom);
      reg_data1 = W'($urandom);
      reg_data2 = W'($urandom);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      obs.acc = accum;
      obs.pc  = pc_branch;
      obs.z   = flag_z;
      obs.c   = flag_c;
      obs.v   = flag_v;
      obs.err = flag_err;
      obs.lat = 8'(lat);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      res_t obs, e;
      logic seen;
      #1;
      checks++;
      if ({out_valid, in_ready, accum, pc_branch, flag_z, flag_c, flag_v, flag_err} !==
          {1'b0, 1'b1, 16'h0000, 5'b00000}) begin
         errors++;
         $display("FAIL reset_init got ov=%b rdy=%b acc=%h flags=%b want ov=0 rdy=1 acc=0000 flags=00000",
                  out_valid, in_ready, accum, {pc_branch, flag_z, flag_c, flag_v, flag_err});
      end
      e = '{acc: 16'h1235, pc: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0, err: 1'b0, lat: 8'd1};
      exp_q.push_back(e);
      do_op(OP_ADD, 16'h1234, 16'h0001, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL reset_pre_add got %s want %s", fmt(obs), fmt(e));
      end
      // Start a long shift and reset it part way through.
      @(negedge clk);
      alu_code  = OP_SLL;
      reg_data1 = 16'h0001;
      reg_data2 = 16'h000F;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b00) begin
         errors++;
         $display("FAIL reset_hold got rdy=%b ov=%b want rdy=0 ov=0", in_ready, out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if ({out_valid, in_ready, accum, pc_branch, flag_z, flag_c, flag_v, flag_err} !==
          {1'b0, 1'b1, 16'h0000, 5'b00000}) begin
         errors++;
         $display("FAIL reset_release got ov=%b rdy=%b acc=%h flags=%b want ov=0 rdy=1 acc=0000 flags=00000",
                  out_valid, in_ready, accum, {pc_branch, flag_z, flag_c, flag_v, flag_err});
      end
      seen = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_abandon got out_valid=1 after reset want 0");
      end
   endtask

   task automatic test_arith();
      vec_t v[19];
      res_t obs, e;
      v = '{
         {OP_ADD, 16'h0001, 16'h003F, 16'h0040, 5'b00000, 8'd1},
         {OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 5'b00010, 8'd1},
         {OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 5'b01100, 8'd1},
         {OP_SUB, 16'h003F, 16'h0001, 16'h003E, 5'b00000, 8'd1},
         {OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 5'b00100, 8'd1},
         {OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 5'b00010, 8'd1},
         {OP_BEQ, 16'h0001, 16'h0001, 16'h0000, 5'b11000, 8'd1},
         {OP_BEQ, 16'h0001, 16'h0002, 16'hFFFF, 5'b00100, 8'd1},
         {OP_BLT, 16'h0001, 16'h0003, 16'hFFFE, 5'b10100, 8'd1},
         {OP_BLT, 16'h0003, 16'h0001, 16'h0002, 5'b00000, 8'd1},
         {OP_BLT, 16'h8000, 16'h0001, 16'h7FFF, 5'b00010, 8'd1},
         {OP_BGT, 16'h0001, 16'h0003, 16'hFFFE, 5'b00100, 8'd1},
         {OP_BGT, 16'h0003, 16'h0001, 16'h0002, 5'b10000, 8'd1},
         {OP_ADD, 16'h0005, 16'h0005, 16'h000A, 5'b00000, 8'd1},
         {OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 5'b00000, 8'd1},
         {OP_OR,  16'h00F0, 16'h0F00, 16'h0FF0, 5'b00000, 8'd1},
         {OP_XOR, 16'hAAAA, 16'hAAAA, 16'h0000, 5'b01000, 8'd1},
         {4'b0000, 16'h0005, 16'h0005, 16'h0000, 5'b00001, 8'd1},
         {4'b1111, 16'hFFFF, 16'hFFFF, 16'h0000, 5'b00001, 8'd1}
      };
      for (int i = 0; i < 19; i++) begin
         exp_q.push_back(v[i].e);
         do_op(v[i].code, v[i].a, v[i].b, obs);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL arith[%0d] code=%b got %s want %s", i, v[i].code, fmt(obs), fmt(e));
         end
      end
      for (int i = 0; i < 6; i++) begin
         logic [3:0]   code;
         logic [W-1:0] a, b;
         code = (i % 2 == 0) ? OP_ADD : OP_SUB;
         a = W'($urandom);
         b = W'($urandom);
         exp_q.push_back(model(code, a, b));
         do_op(code, a, b, obs);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL arith_rand[%0d] a=%h b=%h got %s want %s", i, a, b, fmt(obs), fmt(e));
         end
      end
   endtask

   task automatic test_shift();
      vec_t v[5];
      res_t obs, e;
      v = '{
         {OP_SLL, 16'h0001, 16'h000F, 16'h8000, 5'b00000, 8'd16},
         {OP_SRL, 16'h1234, 16'h0000, 16'h1234, 5'b00000, 8'd1},
         {OP_SRL, 16'h8000, 16'h0004, 16'h0800, 5'b00000, 8'd5},
         {OP_SLL, 16'h0001, 16'h0013, 16'h0008, 5'b00000, 8'd4},
         {OP_SRL, 16'h0001, 16'h0001, 16'h0000, 5'b01000, 8'd2}
      };
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(v[i].e);
         do_op(v[i].code, v[i].a, v[i].b, obs);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL shift[%0d] code=%b got %s want %s", i, v[i].code, fmt(obs), fmt(e));
         end
      end
   endtask

   task automatic test_mul();
      vec_t v[3];
      res_t obs, e;
`ifdef SEQ_ALU_MUL_EN
      v = '{
         {OP_MUL, 16'h0100, 16'h0100, 16'h0000, 5'b01010, 8'd17},
         {OP_MUL, 16'h0003, 16'h0005, 16'h000F, 5'b00000, 8'd17},
         {OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 5'b00010, 8'd17}
      };
`else
      v = '{
         {OP_MUL, 16'h0100, 16'h0100, 16'h0000, 5'b00001, 8'd1},
         {OP_MUL, 16'h0003, 16'h0005, 16'h0000, 5'b00001, 8'd1},
         {OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0000, 5'b00001, 8'd1}
      };
`endif
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(v[i].e);
         do_op(v[i].code, v[i].a, v[i].b, obs);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL mul[%0d] got %s want %s", i, fmt(obs), fmt(e));
         end
      end
   endtask

   task automatic test_hold();
      logic [W+6:0] snap;
      @(negedge clk);
      alu_code  = OP_ADD;
      reg_data1 = 16'h0010;
      reg_data2 = 16'h0020;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      // Keep presenting other ops while the result waits for the consumer.
      for (int i = 0; i < 5; i++) begin
         alu_code  = OP_SUB;
         reg_data1 = W'($urandom);
         reg_data2 = W'($urandom);
         snap = {out_valid, in_ready, accum, pc_branch, flag_z, flag_c, flag_v, flag_err};
         checks++;
         if (snap !== {1'b1, 1'b0, 16'h0030, 5'b00000}) begin
            errors++;
            $display("FAIL hold[%0d] got ov=%b rdy=%b acc=%h flags=%b want ov=1 rdy=0 acc=0030 flags=00000",
                     i, snap[W+6], snap[W+5], snap[W+4:5], snap[4:0]);
         end
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({out_valid, in_ready, accum} !== {1'b0, 1'b1, 16'h0030}) begin
         errors++;
         $display("FAIL hold_idle got ov=%b rdy=%b acc=%h want ov=0 rdy=1 acc=0030",
                  out_valid, in_ready, accum);
      end
   endtask

   task automatic test_back_to_back();
      localparam int N = 8;
      logic [3:0]   codes[N];
      logic [W-1:0] as[N], bs[N];
      res_t obs, e;
      int   idx, cyc;
      for (int i = 0; i < N; i++) begin
         case ($urandom_range(0, 4))
            0: codes[i] = OP_ADD;
            1: codes[i] = OP_SUB;
            2: codes[i] = OP_AND;
            3: codes[i] = OP_OR;
            default: codes[i] = OP_XOR;
         endcase
         as[i] = W'($urandom);
         bs[i] = W'($urandom);
      end
      idx = 0;
      cyc = 0;
      out_ready = 1'b1;
      while ((idx < N || exp_q.size() > 0) && cyc < 200) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            obs.acc = accum;
            obs.pc  = pc_branch;
            obs.z   = flag_z;
            obs.c   = flag_c;
            obs.v   = flag_v;
            obs.err = flag_err;
            obs.lat = 8'd1;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL b2b_extra got %s want no result", fmt(obs));
            end else begin
               e = exp_q.pop_front();
               if (obs !== e) begin
                  errors++;
                  $display("FAIL b2b got %s want %s", fmt(obs), fmt(e));
               end
            end
         end
         in_valid = (idx < N);
         if (idx < N) begin
            alu_code  = codes[idx];
            reg_data1 = as[idx];
            reg_data2 = bs[idx];
            if (in_ready === 1'b1) begin
               exp_q.push_back(model(codes[idx], as[idx], bs[idx]));
               idx++;
            end
         end
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (cyc != 2 * N) begin
         errors++;
         $display("FAIL b2b_throughput got %0d cycles want %0d", cyc, 2 * N);
      end
      exp_q.delete();
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      alu_code  = 4'b0000;
      reg_data1 = '0;
      reg_data2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_arith();
      test_shift();
      test_mul();
      test_hold();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
